// File: rtl/byteena_regfile.sv
// byteena_regfile: DEPTH x (8*NBYTES) register file with per-byte write
// enables, selectable masking of disabled bytes, and a registered read port
// that forwards a same-cycle write to the same address (write-first).
module byteena_regfile #(
  parameter int NBYTES = 2,
  parameter int ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [NBYTES-1:0]     byteena,
  input  logic [8*NBYTES-1:0]   wr_data,
  input  logic                  mask_mode,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [8*NBYTES-1:0]   rd_data,
  output logic                  rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int WIDTH = 8 * NBYTES;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] merged_word;

  // Build the post-write word for wr_addr: enabled lanes take new data,
  // disabled lanes either keep the stored byte or are zeroed by mask_mode.
  always_comb begin
    merged_word = mem[wr_addr];
    for (int i = 0; i < NBYTES; i++) begin
      if (byteena[i]) begin
        merged_word[8*i +: 8] = wr_data[8*i +: 8];
      end else if (mask_mode) begin
        merged_word[8*i +: 8] = 8'h00;
      end
    end
  end

  // Storage update: reset clears every word and blocks any write that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        mem[d] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= merged_word;
    end
  end

  // Registered read port; a write to the same address in the same cycle is
  // forwarded so the reader sees the merged word rather than stale storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (wr_en && (wr_addr == rd_addr)) begin
          rd_data <= merged_word;
        end else begin
          rd_data <= mem[rd_addr];
        end
      end
    end
  end

endmodule

// File: doc/byteena_regfile.md
Name: byteena_regfile

Overview:
- Parametrised storage successor to the 16-bit byte-enable masking block.
- Holds DEPTH words of NBYTES bytes each.
- Each write applies a per-byte enable. In the selectable mode, disabled bytes are either preserved or forced to zero.
- Provides a registered read port with same-cycle write-first forwarding. Sits between a byte-granular bus master and downstream datapath logic.

Parameters:
- NBYTES, 2, number of byte lanes per word; word width is 8*NBYTES.
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W words, so every address is valid.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe, sampled on rising edge of clk.
- wr_addr  input  ADDR_W  write word address.
- byteena  input  NBYTES  per-byte write enable; bit i gates bits [8i+7:8i].
- wr_data  input  8*NBYTES  write data.
- mask_mode  input  1  0 = disabled bytes keep the stored value; 1 = disabled bytes are written as 8'h00.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  read word address.
- rd_data  output  8*NBYTES  registered read data.
- rd_valid  output  1  high for exactly one cycle per accepted read.

Behaviour:
- Reset (reset=1 at clock edge):
  - all DEPTH words become 0.
  - rd_data becomes 0; rd_valid becomes 0.
  - reset has priority over wr_en and rd_en in the same cycle; no write is performed and no read is returned.
- Write (wr_en=1, reset=0), for each lane i of mem[wr_addr]:
  - byteena[i]=1: lane takes wr_data lane i.
  - byteena[i]=0 and mask_mode=0: lane unchanged.
  - byteena[i]=0 and mask_mode=1: lane becomes 8'h00.
  - Other words are never touched.
- Write edge cases:
  - byteena all zero with mask_mode=0: no storage change (legal no-op).
  - byteena all zero with mask_mode=1: the addressed word is cleared.
  - mask_mode is sampled in the same cycle as wr_en; changing it between writes is legal.
- Read (rd_en=1, reset=0):
  - rd_data is loaded with mem[rd_addr] at the same edge; visible the cycle after rd_en.
  - rd_valid=1 that cycle.
  - Latency is 1 cycle; a new read can be issued every cycle (full throughput).
- Read forwarding: rd_en and wr_en in the same cycle with rd_addr==wr_addr returns the post-write merged word (write-first), including any mask_mode zeroing.
  - Different addresses: the read returns the old contents of rd_addr, unaffected by the write.
- No read (rd_en=0): rd_valid=0 next cycle; rd_data holds its last value.
- Storage holds its value indefinitely when idle; no latches anywhere. All storage is clocked flops or inferred RAM with synchronous write.

Test Plan (NBYTES=2, ADDR_W=2):
1. Reset, then read all 4 addresses back-to-back -> rd_data=16'h0000 each cycle, rd_valid high for 4 consecutive cycles starting one cycle after first rd_en.
2. Write addr1 16'hABCD with byteena=2'b11, then addr1 16'h1234 with byteena=2'b01, mask_mode=0, then read addr1 -> 16'hAB34.
3. Repeat step 2's second write with mask_mode=1, then read addr1 -> 16'h0034; write addr2 with byteena=2'b00, mask_mode=1 after preloading 16'hFFFF -> reading addr2 gives 16'h0000.
4. Preload addr3=16'h5555. In one cycle, write addr3 16'hAAAA with byteena=2'b10 (mask_mode=0) and read addr3 -> rd_data=16'hAA55 next cycle. In one cycle, write addr0 and read addr3 -> returns the unmodified addr3 value.
5. Assert reset in the same cycle as wr_en=1 and rd_en=1 to addr1 -> rd_valid=0 next cycle, and a later read of addr1 returns 16'h0000.
6. Idle 10 cycles with rd_en=0 after a read returning 16'hAB34 -> rd_data stays 16'hAB34 and rd_valid stays 0 throughout.
